// File: rtl/multi_signal_sync_pkg.sv
// rtl/multi_signal_sync_pkg.sv - shared mode encodings for multi_signal_sync
package multi_signal_sync_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_ANY   = 2'b11;

endpackage

// File: rtl/multi_signal_sync_ch.sv
// rtl/multi_signal_sync_ch.sv - one channel: sync chain, glitch filter, edge pulse, sticky flags
// Glitch filter is built only when MULTI_SIGNAL_SYNC_FILTER_EN is defined.
module multi_signal_sync_ch
    import multi_signal_sync_pkg::*;
#(
    parameter int   C_SYNC_STAGES = 2,
    parameter int   C_FILT_WIDTH  = 4,
    parameter logic C_RESET_VAL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    async_in,
    input  logic [1:0]              mode,
    input  logic [C_FILT_WIDTH-1:0] filt_thresh,
    input  logic                    event_clr,
    output logic                    level_out,
    output logic                    pulse_out,
    output logic                    event_pending,
    output logic                    event_overrun
);

    (* ASYNC_REG = "TRUE" *) logic [C_SYNC_STAGES-1:0] sync_q;
    logic sync;
    logic filt;
    logic filt_d;
    logic pulse_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {C_SYNC_STAGES{C_RESET_VAL}};
        else     sync_q <= {sync_q[C_SYNC_STAGES-2:0], async_in};
    end

    assign sync = sync_q[C_SYNC_STAGES-1];

`ifdef MULTI_SIGNAL_SYNC_FILTER_EN
    logic [C_FILT_WIDTH-1:0] cnt;
    logic [C_FILT_WIDTH-1:0] t_m1;

    // A threshold of zero behaves like one; ">=" lets a lowered threshold fire at once.
    assign t_m1 = (filt_thresh == '0) ? '0 : filt_thresh - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= C_RESET_VAL;
        end else if (sync == filt) begin
            cnt <= '0;
        end else if (cnt >= t_m1) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^filt_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) filt <= C_RESET_VAL;
        else     filt <= sync;
    end
`endif

    always_comb begin
        pulse_d = 1'b0;
        case (mode)
            MODE_RISE: pulse_d = filt & ~filt_d;
            MODE_FALL: pulse_d = ~filt & filt_d;
            MODE_ANY:  pulse_d = filt ^ filt_d;
            default:   pulse_d = 1'b0;
        endcase
    end

    // Flags follow the registered pulse, so a clear seen alongside pulse_out keeps the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_d        <= C_RESET_VAL;
            pulse_out     <= 1'b0;
            event_pending <= 1'b0;
            event_overrun <= 1'b0;
        end else begin
            filt_d    <= filt;
            pulse_out <= pulse_d;
            if (event_clr) begin
                event_pending <= pulse_out;
                event_overrun <= 1'b0;
            end else if (pulse_out) begin
                event_pending <= 1'b1;
                event_overrun <= event_overrun | event_pending;
            end
        end
    end

    assign level_out = filt;

endmodule

// File: rtl/multi_signal_sync.sv
// rtl/multi_signal_sync.sv - C_NUM_CH independent synchronizer channels (filter: MULTI_SIGNAL_SYNC_FILTER_EN)
module multi_signal_sync
    import multi_signal_sync_pkg::*;
#(
    parameter int                  C_NUM_CH      = 4,
    parameter int                  C_SYNC_STAGES = 2,
    parameter int                  C_FILT_WIDTH  = 4,
    parameter logic [C_NUM_CH-1:0] C_RESET_VAL   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_NUM_CH-1:0]     async_in,
    input  logic [2*C_NUM_CH-1:0]   mode,
    input  logic [C_FILT_WIDTH-1:0] filt_thresh,
    output logic [C_NUM_CH-1:0]     level_out,
    output logic [C_NUM_CH-1:0]     pulse_out,
    output logic [C_NUM_CH-1:0]     event_pending,
    output logic [C_NUM_CH-1:0]     event_overrun,
    input  logic [C_NUM_CH-1:0]     event_clr
);

    if (C_SYNC_STAGES < 2) begin : g_bad_stages
        $error("multi_signal_sync: C_SYNC_STAGES must be at least 2");
    end

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
        multi_signal_sync_ch #(
            .C_SYNC_STAGES (C_SYNC_STAGES),
            .C_FILT_WIDTH  (C_FILT_WIDTH),
            .C_RESET_VAL   (C_RESET_VAL[i])
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .async_in      (async_in[i]),
            .mode          (mode[2*i+1:2*i]),
            .filt_thresh   (filt_thresh),
            .event_clr     (event_clr[i]),
            .level_out     (level_out[i]),
            .pulse_out     (pulse_out[i]),
            .event_pending (event_pending[i]),
            .event_overrun (event_overrun[i])
        );
    end

endmodule

// File: tb/tb_multi_signal_sync.sv
// tb/tb_multi_signal_sync.sv - directed self-checking bench for multi_signal_sync
module tb_multi_signal_sync;

    localparam int NCH = 4;
    localparam int SYN = 2;
    localparam int FW  = 4;
    localparam logic [NCH-1:0] RV = 4'b0101;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] async_in;
    logic [2*NCH-1:0] mode;
    logic [FW-1:0]  filt_thresh;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] pulse_out;
    logic [NCH-1:0] event_pending;
    logic [NCH-1:0] event_overrun;
    logic [NCH-1:0] event_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_signal_sync #(
        .C_NUM_CH      (NCH),
        .C_SYNC_STAGES (SYN),
        .C_FILT_WIDTH  (FW),
        .C_RESET_VAL   (RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .async_in      (async_in),
        .mode          (mode),
        .filt_thresh   (filt_thresh),
        .level_out     (level_out),
        .pulse_out     (pulse_out),
        .event_pending (event_pending),
        .event_overrun (event_overrun),
        .event_clr     (event_clr)
    );

    function automatic int t_eff(input int th);
`ifdef MULTI_SIGNAL_SYNC_FILTER_EN
        return (th == 0) ? 1 : th;
`else
        return 1;
`endif
    endfunction

    function automatic bit filt_on();
`ifdef MULTI_SIGNAL_SYNC_FILTER_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; async_in = RV; mode = '0; event_clr = '0; filt_thresh = 4'd3;
        #1;
        n_checks++;
        if (level_out !== RV || pulse_out !== 4'b0 || event_pending !== 4'b0 || event_overrun !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_async: level=%b pulse=%b pend=%b ovr=%b required level=%b others 0",
                     level_out, pulse_out, event_pending, event_overrun, RV);
        end
        step(); step();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if (level_out !== RV || pulse_out !== 4'b0 || event_pending !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: level=%b pulse=%b pend=%b required level=%b pulse=0 pend=0",
                         k, level_out, pulse_out, event_pending, RV);
            end
        end
    endtask

    task automatic test_rise();
        int l;
        int npulse;
        async_in[0] = 1'b0; mode[1:0] = 2'b00; filt_thresh = 4'd3;
        npulse = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            npulse += int'(pulse_out[0]);
        end
        n_checks++;
        if (level_out[0] !== 1'b0 || npulse != 0 || event_pending[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL level_mode_fall: level=%b pulses=%0d pend=%b required 0 0 0",
                     level_out[0], npulse, event_pending[0]);
        end
        mode[1:0] = 2'b01;
        async_in[0] = 1'b1;
        l = SYN + t_eff(3);
        for (int k = 1; k <= l + 4; k++) begin
            step();
            n_checks++;
            if (level_out[0] !== (k >= l) || pulse_out[0] !== (k == l + 1) || event_pending[0] !== (k >= l + 2)) begin
                n_fail++;
                $display("FAIL rise_ch0 cyc %0d: level=%b pulse=%b pend=%b required %b %b %b",
                         k, level_out[0], pulse_out[0], event_pending[0], k >= l, k == l + 1, k >= l + 2);
            end
        end
    endtask

    task automatic test_glitch();
        int l;
        bit exp_lvl;
        bit exp_pls;
        filt_thresh = 4'd4; mode[3:2] = 2'b01;
        step(); step();
        async_in[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 2) async_in[1] = 1'b0;
            exp_lvl = !filt_on() && (k == 3 || k == 4);
            exp_pls = !filt_on() && (k == 4);
            n_checks++;
            if (level_out[1] !== exp_lvl || pulse_out[1] !== exp_pls) begin
                n_fail++;
                $display("FAIL glitch_ch1 cyc %0d: level=%b pulse=%b required %b %b",
                         k, level_out[1], pulse_out[1], exp_lvl, exp_pls);
            end
        end
        event_clr = 4'b0010;
        step();
        event_clr = '0;
        n_checks++;
        if (event_pending[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_clr: pend=%b required 0", event_pending[1]);
        end
        async_in[1] = 1'b1;
        l = SYN + t_eff(4);
        for (int k = 1; k <= l + 2; k++) begin
            step();
            n_checks++;
            if (level_out[1] !== (k >= l)) begin
                n_fail++;
                $display("FAIL stable_ch1 cyc %0d: level=%b required %b", k, level_out[1], k >= l);
            end
        end
    endtask

    task automatic test_thresh15();
        int l;
        bit exp_lvl;
        filt_thresh = 4'd15; mode[3:2] = 2'b00;
        step(); step(); step();
        async_in[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) async_in[1] = 1'b1;
            exp_lvl = filt_on() || (k != 3);
            n_checks++;
            if (level_out[1] !== exp_lvl || pulse_out[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch15_ch1 cyc %0d: level=%b pulse=%b required %b 0",
                         k, level_out[1], pulse_out[1], exp_lvl);
            end
        end
        mode[3:2] = 2'b10;
        async_in[1] = 1'b0;
        l = SYN + t_eff(15);
        for (int k = 1; k <= l + 3; k++) begin
            step();
            n_checks++;
            if (pulse_out[1] !== (k == l + 1)) begin
                n_fail++;
                $display("FAIL fall_latency_ch1 cyc %0d: pulse=%b required %b", k, pulse_out[1], k == l + 1);
            end
        end
    endtask

    task automatic test_overrun();
        int npulse;
        filt_thresh = 4'd1; mode[5:4] = 2'b11;
        step(); step();
        npulse = 0;
        async_in[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            npulse += int'(pulse_out[2]);
        end
        async_in[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            npulse += int'(pulse_out[2]);
        end
        n_checks++;
        if (npulse != 2 || event_pending[2] !== 1'b1 || event_overrun[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_ch2: pulses=%0d pend=%b ovr=%b required 2 1 1",
                     npulse, event_pending[2], event_overrun[2]);
        end
        event_clr = 4'b0100;
        step();
        event_clr = '0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (event_pending[2] !== 1'b0 || event_overrun[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL overrun_clr_ch2 cyc %0d: pend=%b ovr=%b required 0 0",
                         k, event_pending[2], event_overrun[2]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back_clr();
        int l;
        filt_thresh = 4'd1; mode[7:6] = 2'b01;
        step(); step();
        async_in[3] = 1'b1;
        l = SYN + t_eff(1);
        for (int k = 1; k <= l + 1; k++) step();
        n_checks++;
        if (pulse_out[3] !== 1'b1 || event_pending[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_ch3: pulse=%b pend=%b required 1 0", pulse_out[3], event_pending[3]);
        end
        event_clr = 4'b1000;
        step();
        event_clr = '0;
        n_checks++;
        if (event_pending[3] !== 1'b1 || event_overrun[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_with_pulse_ch3: pend=%b ovr=%b required 1 0", event_pending[3], event_overrun[3]);
        end
        mode[7:6] = 2'b10;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_checks++;
            if (pulse_out[3] !== 1'b0 || level_out[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL mode_change_ch3 cyc %0d: pulse=%b level=%b required 0 1",
                         k, pulse_out[3], level_out[3]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_thresh15();
        test_overrun();
        test_back_to_back_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
